// File: rtl/sensor_poll_scheduler_if.sv
// Sensor poll scheduler bus: requester handshake, enables, status/telemetry.
//   master : scheduler side (drives START/status, samples ENABLE/DONE/CLEAR)
//   slave  : requester/housekeeping side
// Signals:
//   ENABLE_IN          per-requester enable, sampled at frame start
//   DONE_IN            per-requester completion
//   CLEAR_IN           one-cycle clear of sticky flags
//   START_OUT          one-hot start pulse
//   ACTIVE_IDX_OUT     requester being serviced
//   BUSY_OUT           frame in service
//   TICK_OUT           1 ms tick pulse
//   FRAME_COUNT_OUT    frames started (mod 2^16)
//   TIMEOUT_FLAGS_OUT  sticky per-requester timeout flags
//   OVERRUN_OUT        sticky frame overrun flag
interface sensor_poll_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] ENABLE_IN;
  logic [NUM_REQ-1:0] DONE_IN;
  logic               CLEAR_IN;
  logic [NUM_REQ-1:0] START_OUT;
  logic [IDX_W-1:0]   ACTIVE_IDX_OUT;
  logic               BUSY_OUT;
  logic               TICK_OUT;
  logic [15:0]        FRAME_COUNT_OUT;
  logic [NUM_REQ-1:0] TIMEOUT_FLAGS_OUT;
  logic               OVERRUN_OUT;

  modport master (
    input  ENABLE_IN, DONE_IN, CLEAR_IN,
    output START_OUT, ACTIVE_IDX_OUT, BUSY_OUT, TICK_OUT,
           FRAME_COUNT_OUT, TIMEOUT_FLAGS_OUT, OVERRUN_OUT
  );

  modport slave (
    output ENABLE_IN, DONE_IN, CLEAR_IN,
    input  START_OUT, ACTIVE_IDX_OUT, BUSY_OUT, TICK_OUT,
           FRAME_COUNT_OUT, TIMEOUT_FLAGS_OUT, OVERRUN_OUT
  );
endinterface

// File: rtl/sensor_poll_scheduler.sv
// Frame scheduler for the sensor-read engines. Derives a 1 ms tick from the
// 1 MHz clock, groups ticks into frames, and at each frame start triggers
// every enabled requester in ascending index order with a START/DONE
// handshake guarded by a timeout.
// Ports:
//   CLK_1MHZ_IN  1 MHz clock, rising edge
//   RESET_IN     synchronous active-high reset
//   bus          scheduler side of sensor_poll_scheduler_if (master)
module sensor_poll_scheduler #(
  parameter int TICK_DIV    = 1000,
  parameter int FRAME_TICKS = 10,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 500
) (
  input  logic                     CLK_1MHZ_IN,
  input  logic                     RESET_IN,
  sensor_poll_scheduler_if.master  bus
);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FT_W   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYC) + 1;
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, WAIT} state_t;

  state_t             r_state;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [FT_W-1:0]    r_frame_tick;
  logic [NUM_REQ-1:0] r_mask;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_REQ-1:0] r_start;
  logic               r_busy;
  logic [15:0]        r_frame_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [NUM_REQ-1:0] r_flags;
  logic               r_ovr;

  logic               w_tick;
  logic               w_frame_start;
  logic               w_done;
  logic               w_to_hit;
  logic [IDX_W-1:0]   w_sel;

  assign w_tick        = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
  assign w_frame_start = w_tick && (r_frame_tick == '0);
  assign w_done        = bus.DONE_IN[r_idx];
  assign w_to_hit      = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Lowest set bit of the pending mask wins.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_mask[NUM_REQ-1-i]) w_sel = IDX_W'(NUM_REQ - 1 - i);
    end
  end

  always_ff @(posedge CLK_1MHZ_IN) begin
    if (RESET_IN) begin
      r_state      <= IDLE;
      r_tick_cnt   <= '0;
      r_frame_tick <= '0;
      r_mask       <= '0;
      r_idx        <= '0;
      r_start      <= '0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
      r_to_cnt     <= '0;
      r_flags      <= '0;
      r_ovr        <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        r_frame_tick <= (r_frame_tick == FT_W'(FRAME_TICKS - 1)) ? '0 : r_frame_tick + 1'b1;
      end

      // Clear first so that any set below in the same cycle overrides it.
      if (bus.CLEAR_IN) begin
        r_flags <= '0;
        r_ovr   <= 1'b0;
      end
      if (w_frame_start && r_busy) r_ovr <= 1'b1;

      r_start <= '0;
      case (r_state)
        IDLE: begin
          if (w_frame_start && !r_busy) begin
            r_mask      <= bus.ENABLE_IN;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_busy      <= 1'b1;
            r_state     <= SCAN;
          end else begin
            // BUSY falls one cycle after returning here, so even an empty
            // frame shows two busy cycles (SCAN plus this one).
            r_busy <= 1'b0;
          end
        end
        SCAN: begin
          if (|r_mask) begin
            r_idx   <= w_sel;
            r_start <= NUM_REQ'(1) << w_sel;
            r_state <= ISSUE;
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (w_done) begin
            r_mask[r_idx] <= 1'b0;
            r_state       <= SCAN;
          end else if (w_to_hit) begin
            r_flags[r_idx] <= 1'b1;
            r_mask[r_idx]  <= 1'b0;
            r_state        <= SCAN;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.START_OUT         = r_start;
  assign bus.ACTIVE_IDX_OUT    = r_idx;
  assign bus.BUSY_OUT          = r_busy;
  assign bus.TICK_OUT          = w_tick;
  assign bus.FRAME_COUNT_OUT   = r_frame_cnt;
  assign bus.TIMEOUT_FLAGS_OUT = r_flags;
  assign bus.OVERRUN_OUT       = r_ovr;
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler. Instance A uses default
// parameters; instance B (FRAME_TICKS=1, TIMEOUT_CYC=1500) exercises overrun.
// Cycle k is the k-th clock period after the last edge that sampled reset;
// outputs are sampled and inputs driven at the falling edge.
module tb_sensor_poll_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic quiet = 1'b0;
  logic start_seen = 1'b0;
  logic multi_hot = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  sensor_poll_scheduler_if #(.NUM_REQ(4)) a_if ();
  sensor_poll_scheduler_if #(.NUM_REQ(4)) b_if ();

  sensor_poll_scheduler #(.TICK_DIV(1000), .FRAME_TICKS(10), .NUM_REQ(4), .TIMEOUT_CYC(500))
    u_a (.CLK_1MHZ_IN(clk), .RESET_IN(rst), .bus(a_if.master));
  sensor_poll_scheduler #(.TICK_DIV(1000), .FRAME_TICKS(1), .NUM_REQ(4), .TIMEOUT_CYC(1500))
    u_b (.CLK_1MHZ_IN(clk), .RESET_IN(rst), .bus(b_if.master));

  always @(negedge clk) begin
    if (quiet && a_if.START_OUT != 4'b0000) start_seen = 1'b1;
    if ($countones(a_if.START_OUT) > 1 || $countones(b_if.START_OUT) > 1) multi_hot = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    a_if.ENABLE_IN = 4'b0000; a_if.DONE_IN = 4'b0000; a_if.CLEAR_IN = 1'b0;
    b_if.ENABLE_IN = 4'b0001; b_if.DONE_IN = 4'b0000; b_if.CLEAR_IN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(a_if.START_OUT), 0);
    chk("rst_busy", 32'(a_if.BUSY_OUT), 0);
    chk("rst_tick", 32'(a_if.TICK_OUT), 0);
    chk("rst_fc", 32'(a_if.FRAME_COUNT_OUT), 0);
    chk("rst_flags", 32'(a_if.TIMEOUT_FLAGS_OUT), 0);
    chk("rst_ovr", 32'(a_if.OVERRUN_OUT), 0);
    chk("rst_idx", 32'(a_if.ACTIVE_IDX_OUT), 0);
    rst = 1'b0;
    quiet = 1'b1;

    // Phase 1: nothing enabled; ticks and empty frames only.
    goto(998);  chk("tick_998", 32'(a_if.TICK_OUT), 0);
    goto(999);  chk("tick_999", 32'(a_if.TICK_OUT), 1);
                chk("busy_999", 32'(a_if.BUSY_OUT), 0);
                chk("fc_999", 32'(a_if.FRAME_COUNT_OUT), 0);
    goto(1000); chk("tick_1000", 32'(a_if.TICK_OUT), 0);
                chk("busy_1000", 32'(a_if.BUSY_OUT), 1);
                chk("fc_1000", 32'(a_if.FRAME_COUNT_OUT), 1);
    goto(1001); chk("busy_1001", 32'(a_if.BUSY_OUT), 1);
    goto(1002); chk("busy_1002", 32'(a_if.BUSY_OUT), 0);
    goto(1999); chk("tick_1999", 32'(a_if.TICK_OUT), 1);
    // Instance B: tick 2 arrives while requester 0 is still pending.
    goto(2000); chk("b_ovr", 32'(b_if.OVERRUN_OUT), 1);
                chk("b_fc_drop", 32'(b_if.FRAME_COUNT_OUT), 1);
    goto(2501); chk("b_flag_pre", 32'(b_if.TIMEOUT_FLAGS_OUT), 0);
    goto(2502); chk("b_flag", 32'(b_if.TIMEOUT_FLAGS_OUT), 32'h1);
    goto(3000); chk("b_fc_next", 32'(b_if.FRAME_COUNT_OUT), 2);
    goto(21000); chk("fc_tick21", 32'(a_if.FRAME_COUNT_OUT), 3);
    goto(25000); chk("no_start", 32'(start_seen), 0);
    quiet = 1'b0;

    // Phase 2: requesters 0,1,3, DONE 20 cycles after each START.
    a_if.ENABLE_IN = 4'b1011;
    goto(31000); chk("p2_fc", 32'(a_if.FRAME_COUNT_OUT), 4);
                 chk("p2_start_t1", 32'(a_if.START_OUT), 0);
    goto(31001); chk("p2_start0", 32'(a_if.START_OUT), 32'h1);
                 chk("p2_idx0", 32'(a_if.ACTIVE_IDX_OUT), 0);
    goto(31002); chk("p2_start_pulse", 32'(a_if.START_OUT), 0);
    goto(31021); a_if.DONE_IN = 4'b0001;
    goto(31022); a_if.DONE_IN = 4'b0000;
    goto(31023); chk("p2_start1", 32'(a_if.START_OUT), 32'h2);
                 chk("p2_idx1", 32'(a_if.ACTIVE_IDX_OUT), 1);
    goto(31030); a_if.ENABLE_IN = 4'b0100;
    goto(31043); a_if.DONE_IN = 4'b0010;
    goto(31044); a_if.DONE_IN = 4'b0000;
    goto(31045); chk("p2_start3", 32'(a_if.START_OUT), 32'h8);
                 chk("p2_idx3", 32'(a_if.ACTIVE_IDX_OUT), 3);
    goto(31065); a_if.DONE_IN = 4'b1000;
    goto(31066); a_if.DONE_IN = 4'b0000;
    goto(31067); chk("p2_busy_tail", 32'(a_if.BUSY_OUT), 1);
    goto(31068); chk("p2_busy_end", 32'(a_if.BUSY_OUT), 0);
                 chk("p2_flags", 32'(a_if.TIMEOUT_FLAGS_OUT), 0);

    // Phase 3: requester 2 never answers; CLEAR coincides with the timeout.
    goto(41000); chk("p3_fc", 32'(a_if.FRAME_COUNT_OUT), 5);
    goto(41001); chk("p3_start2", 32'(a_if.START_OUT), 32'h4);
                 chk("p3_idx2", 32'(a_if.ACTIVE_IDX_OUT), 2);
    goto(41501); chk("p3_flag_pre", 32'(a_if.TIMEOUT_FLAGS_OUT), 0);
                 a_if.CLEAR_IN = 1'b1;
    goto(41502); a_if.CLEAR_IN = 1'b0;
                 chk("p3_flag_setwins", 32'(a_if.TIMEOUT_FLAGS_OUT), 32'h4);
    goto(41503); chk("p3_busy_tail", 32'(a_if.BUSY_OUT), 1);
    goto(41504); chk("p3_busy_end", 32'(a_if.BUSY_OUT), 0);
    goto(42000); chk("p3_flag_hold", 32'(a_if.TIMEOUT_FLAGS_OUT), 32'h4);
                 a_if.CLEAR_IN = 1'b1;
    goto(42001); a_if.CLEAR_IN = 1'b0;
                 chk("p3_cleared", 32'(a_if.TIMEOUT_FLAGS_OUT), 0);

    // Phase 4: DONE during ISSUE, stray DONE[1], DONE[2] on the timeout cycle.
    goto(51000); chk("p4_fc", 32'(a_if.FRAME_COUNT_OUT), 6);
    goto(51001); chk("p4_start2", 32'(a_if.START_OUT), 32'h4);
                 a_if.DONE_IN = 4'b0100;
    goto(51002); a_if.DONE_IN = 4'b0000;
    goto(51200); a_if.DONE_IN = 4'b0010;
    goto(51201); a_if.DONE_IN = 4'b0000;
    goto(51300); chk("p4_busy_mid", 32'(a_if.BUSY_OUT), 1);
                 chk("p4_idx_mid", 32'(a_if.ACTIVE_IDX_OUT), 2);
    goto(51501); a_if.DONE_IN = 4'b0100;
    goto(51502); a_if.DONE_IN = 4'b0000;
                 chk("p4_donewins", 32'(a_if.TIMEOUT_FLAGS_OUT), 0);
    goto(51504); chk("p4_busy_end", 32'(a_if.BUSY_OUT), 0);

    // Phase 5: reset while waiting on requester 2.
    goto(61100); chk("p5_busy_pre", 32'(a_if.BUSY_OUT), 1);
                 rst = 1'b1;
    @(negedge clk);
    chk("p5_start", 32'(a_if.START_OUT), 0);
    chk("p5_busy", 32'(a_if.BUSY_OUT), 0);
    chk("p5_fc", 32'(a_if.FRAME_COUNT_OUT), 0);
    chk("p5_idx", 32'(a_if.ACTIVE_IDX_OUT), 0);
    chk("p5_b_ovr", 32'(b_if.OVERRUN_OUT), 0);
    chk("p5_b_flags", 32'(b_if.TIMEOUT_FLAGS_OUT), 0);
    rst = 1'b0;
    goto(500);  chk("p5_idle", 32'(a_if.BUSY_OUT), 0);
                chk("p5_idle_start", 32'(a_if.START_OUT), 0);
    goto(998);  chk("p5_tick_998", 32'(a_if.TICK_OUT), 0);
    goto(999);  chk("p5_tick_999", 32'(a_if.TICK_OUT), 1);
    goto(1000); chk("p5_fc1", 32'(a_if.FRAME_COUNT_OUT), 1);
    goto(1001); chk("p5_start2", 32'(a_if.START_OUT), 32'h4);
    chk("onehot", 32'(multi_hot), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
